// File: rtl/config_regfile.sv
// config_regfile
// Configuration register file loaded from a UART byte stream. Every command
// starts with a header byte. Bit 7 selects write (1) or read (0). Bits [6:0]
// hold the register address. A write header is followed by DATA_BYTES payload
// bytes, most significant byte first. A read streams DATA_BYTES bytes back over
// a valid/ready handshake.
//
// Writes land in a shadow copy. The frame engine sees only the active copy,
// which is reloaded from shadow on each commit pulse (frame boundary).
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   rx_data_i      received UART byte
//   rx_valid_i     one-cycle strobe qualifying rx_data_i
//   tx_data_o      readback byte (registered)
//   tx_valid_o     readback byte available (registered)
//   tx_ready_i     transmitter takes tx_data_o when tx_valid_o && tx_ready_i
//   commit_i       frame-boundary pulse, copies shadow to active
//   cfg_out_o      active register image, reg i at [i*DATA_W +: DATA_W]
//   cfg_pending_o  a shadow write happened since the last commit
//   err_o          one-cycle error strobe
//
// The default RESET_VALS assumes the default geometry (NUM_REGS*DATA_W >= 24).
// Override it whenever NUM_REGS or DATA_W is changed.
module config_regfile #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS =
    {{(NUM_REGS*DATA_W-24){1'b0}}, 24'h00F000}
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  input  logic                       commit_i,
  output logic [NUM_REGS*DATA_W-1:0] cfg_out_o,
  output logic                       cfg_pending_o,
  output logic                       err_o
);

  localparam int unsigned DATA_BYTES = (DATA_W + 7) / 8;
  localparam int unsigned BUF_W      = DATA_BYTES * 8;
  localparam int unsigned CNT_W      = $clog2(DATA_BYTES + 1);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RDATA = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [6:0]                 addr_q, addr_d;
  logic [CNT_W-1:0]           byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [BUF_W-1:0]           wbuf_q, wbuf_d;
  logic [BUF_W-1:0]           txbuf_q, txbuf_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       err_q, err_d;
  logic                       pending_q;
  logic [DATA_W-1:0]          shadow_q [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] active_q;

  logic                       hdr_in_range_s;
  logic                       addr_in_range_s;
  logic [DATA_W-1:0]          rd_word_s;
  logic [BUF_W+7:0]           wr_word_s;
  logic [DATA_W-1:0]          wr_data_s;
  logic                       wr_en_s;

  assign hdr_in_range_s  = ({1'b0, rx_data_i[6:0]} < 8'(NUM_REGS));
  assign addr_in_range_s = ({1'b0, addr_q} < 8'(NUM_REGS));

  // The final payload byte joins the bytes already buffered. Padding above
  // DATA_W is dropped here.
  assign wr_word_s = {wbuf_q, rx_data_i};
  assign wr_data_s = wr_word_s[DATA_W-1:0];

  assign tx_data_o     = txbuf_q[BUF_W-1 -: 8];
  assign tx_valid_o    = tx_valid_q;
  assign cfg_out_o     = active_q;
  assign cfg_pending_o = pending_q;
  assign err_o         = err_q;

  // Shadow read mux addressed directly by the incoming header byte.
  // The result is zero when no register matches.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      rd_word_s = rd_word_s | ((rx_data_i[6:0] == 7'(i)) ? shadow_q[i] : {DATA_W{1'b0}});
    end
  end

  // Command FSM next-state and datapath decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    wbuf_d     = wbuf_q;
    txbuf_d    = txbuf_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    wr_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          addr_d     = rx_data_i[6:0];
          byte_cnt_d = '0;
          if (rx_data_i[7]) begin
            state_d = WDATA;
            tmo_d   = '0;
            wbuf_d  = '0;
          end else begin
            state_d    = RDATA;
            tx_valid_d = 1'b1;
            txbuf_d    = hdr_in_range_s ? BUF_W'(rd_word_s) : {BUF_W{1'b0}};
            err_d      = !hdr_in_range_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WDATA: begin
        if (rx_valid_i) begin
          tmo_d  = '0;
          wbuf_d = wr_word_s[BUF_W-1:0];
          if (byte_cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            wr_en_s    = addr_in_range_s;
            err_d      = !addr_in_range_s;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 2)) begin
          // The counter would reach TIMEOUT_CYC-1 on this edge, so abort now.
          state_d    = IDLE;
          byte_cnt_d = '0;
          tmo_d      = '0;
          err_d      = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RDATA: begin
        // A byte received mid-read is dropped. The read itself carries on.
        err_d = rx_valid_i;
        if (tx_ready_i) begin
          txbuf_d = txbuf_q << 8;
          if (byte_cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else begin
          txbuf_d = txbuf_q;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        byte_cnt_d = '0;
      end
    endcase
  end

  // State, shadow/active storage and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 7'd0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      wbuf_q     <= '0;
      txbuf_q    <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      pending_q  <= 1'b0;
      active_q   <= RESET_VALS;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        shadow_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      wbuf_q     <= wbuf_d;
      txbuf_q    <= txbuf_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      // Active samples the pre-write shadow, so a write that coincides with
      // a commit stays pending until the next commit.
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wr_en_s && (addr_q == 7'(i))) begin
          shadow_q[i] <= wr_data_s;
        end
        if (commit_i) begin
          active_q[i*DATA_W +: DATA_W] <= shadow_q[i];
        end
      end
      if (wr_en_s) begin
        pending_q <= 1'b1;
      end else if (commit_i) begin
        pending_q <= 1'b0;
      end else begin
        pending_q <= pending_q;
      end
    end
  end

endmodule

// File: doc/config_regfile.md
Name: config_regfile

Overview:
Parametrised configuration register file driven by a UART byte stream. It replaces the fixed 4-bit nibble-addressed config registers with the following:
- NUM_REGS registers of DATA_W bits each, written by a header-plus-payload protocol.
- Readback over a tx byte handshake.
- Shadow/active double buffering, so the cube driver sees new settings only on a commit (frame boundary).
- A mid-command timeout and an error strobe.

It sits between the UART receiver/transmitter and the LED cube frame engine.

Parameters:
NUM_REGS, 8, number of config registers (1..128)
DATA_W, 12, bits per register (1..32); DATA_BYTES = ceil(DATA_W/8)
TIMEOUT_CYC, 100000, max clk cycles between payload bytes before a write is aborted (>=2)
RESET_VALS, reg1 = 12'h00F and all others 0, packed NUM_REGS*DATA_W reset image; reg i occupies bits [i*DATA_W +: DATA_W]

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received UART byte
rx_valid  in  1  single-cycle strobe, rx_data valid
tx_data  out  8  readback byte
tx_valid  out  1  readback byte available
tx_ready  in  1  transmitter accepts tx_data when tx_valid&&tx_ready
commit  in  1  frame-boundary pulse, copies shadow to active
cfg_out  out  NUM_REGS*DATA_W  active register image
cfg_pending  out  1  shadow differs from active (a write occurred since the last commit)
err  out  1  single-cycle error strobe

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high: rst.
- Reset values:
  - shadow and active = RESET_VALS
  - cfg_out = RESET_VALS
  - tx_valid = 0, tx_data = 0, cfg_pending = 0, err = 0
  - state = IDLE, counters = 0
  - rst mid-command discards the command.
- Header byte: bit7 = 1 for write, 0 for read; bits[6:0] = address.
- FSM states: IDLE, WDATA, RDATA.
- IDLE:
  - On rx_valid, latch the address.
  - Write header: go to WDATA, byte_cnt = 0, timeout counter = 0.
  - Read header: load the tx shift register from shadow[addr] (zero-extended to DATA_BYTES*8) and go to RDATA. An out-of-range address (>= NUM_REGS) loads all-zero bytes and pulses err in the header-accept cycle.
- WDATA:
  - Payload bytes arrive MSB byte first; each rx_valid shifts the byte in and increments byte_cnt.
  - On the DATA_BYTES-th byte, in the same cycle:
    - In range: shadow[addr] <= low DATA_W bits (padding bits ignored), cfg_pending <= 1.
    - Out of range: data is discarded and err pulses.
  - Next state IDLE. Written shadow data is readable by a header accepted the following cycle.
- WDATA timeout:
  - The counter increments each cycle without rx_valid and clears on rx_valid.
  - On reaching TIMEOUT_CYC-1: abort to IDLE, discard the partial word, pulse err. Shadow is unchanged.
- RDATA:
  - tx_valid = 1, tx_data = current byte (MSB byte first).
  - Advance on tx_valid&&tx_ready. After the last byte is accepted, tx_valid drops the next cycle and the state returns to IDLE.
  - tx_data is held stable while tx_valid && !tx_ready.
  - There is no timeout in RDATA.
  - rx_valid during RDATA: the byte is dropped and err pulses; the read continues.
- commit:
  - In any state, when commit=1: active <= shadow and cfg_pending <= 0. Commit without pending is harmless (no change).
  - If commit coincides with a completing shadow write: active takes the pre-write shadow, the new write lands in shadow, and cfg_pending stays 1.
- Registering: cfg_out = active, registered, no combinational path from rx. err is registered, high one cycle per event; coincident events still give a single one-cycle pulse.
- DATA_W=8 gives DATA_BYTES=1; DATA_W=32 gives 4. byte_cnt width = clog2(DATA_BYTES+1).

Test Plan:
1. Reset -> cfg_out = RESET_VALS (reg1 = 0x00F, others 0), tx_valid = 0, cfg_pending = 0. Write 0x83,0x0A,0xBC -> cfg_out unchanged, cfg_pending = 1. Then commit pulse -> cfg_out reg3 = 0xABC, cfg_pending = 0.
2. Read 0x03 after a write of 0xABC, with tx_ready held low 5 cycles then high -> tx_data = 0x0A stable for 6 cycles, then 0x0B... correction: tx_data = 0x0A stable for 6 cycles, then 0xBC, then tx_valid = 0. The read returns the shadow value even before commit.
3. Write 0x85,0x01 then silence for TIMEOUT_CYC cycles (set 16) -> err pulses once at cycle 15 after the last byte. A subsequent read of 0x05 returns 0x00,0x00, and cfg_pending is unchanged.
4. Write to address 0x7F (out of range) with 0xFF,0xFF -> err pulse on the second payload byte, no register changes. Read 0x09 -> bytes 0x00,0x00 plus err at the header.
5. commit asserted in the same cycle as the final payload byte of write reg2 = 0x123 -> cfg_out reg2 keeps its old value, cfg_pending = 1. The next commit -> reg2 = 0x123.
6. Reset asserted after the first payload byte of a write -> all registers = RESET_VALS, state IDLE. The next byte 0x81 is treated as a header.
